// File: rtl/pulse_train_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_train_sequencer
//
// Time-shared pulse/delay scheduler. Walks channels 0..N_CH-1 in order; each
// channel drives its output high for a pulse phase and then low for a delay
// phase. A phase with value V and multiplier M lasts V*(M+1) clocks, and
// V=0 lasts exactly one clock with the output low. The per-channel durations
// and multipliers live in an internal config bank that can only be written
// while the block is idle.
//
// Optional feature: define PTS_LOOP_EN to add the `loop` input. With loop=1
// at the end of the last channel's delay, the train restarts from channel 0
// right after DONE instead of returning to IDLE.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          single-cycle request to begin a train (ignored when busy)
//   abort          synchronous stop, returns to IDLE, highest priority
//   loop           (PTS_LOOP_EN only) repeat the train
//   cfg_we         config write strobe
//   cfg_ch         channel index being written
//   cfg_sel        field: 0=duration 1=delay 2=pulse mult 3=delay mult
//   cfg_data       write data (multipliers use the low MULT_W bits)
//   cfg_rej        one-cycle pulse, the write one cycle earlier was discarded
//   ch_out         registered channel outputs
//   cur_ch         active channel index
//   busy           high in every state except IDLE
//   end_flg        one-cycle pulse while in DONE
// ---------------------------------------------------------------------------
module pulse_train_sequencer #(
    parameter int N_CH   = 16,
    parameter int CNT_W  = 17,
    parameter int MULT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
`ifdef PTS_LOOP_EN
    input  logic              loop,
`endif
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic              cfg_rej,
    output logic [N_CH-1:0]   ch_out,
    output logic [3:0]        cur_ch,
    output logic              busy,
    output logic              end_flg
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, DELAY, DONE} state_t;

    state_t                        state, state_d;
    logic [CH_W-1:0]               ch, ch_d;
    logic [MULT_W-1:0]             pre;
    logic [CNT_W-1:0]              cnt;

    logic [N_CH-1:0][CNT_W-1:0]    dur, dly;
    logic [N_CH-1:0][MULT_W-1:0]   pm, dm;

    logic [N_CH-1:0]               ch_out_d;
    logic [CNT_W-1:0]              v, nxt_dur;
    logic [MULT_W-1:0]             m;
    logic                          cfg_ok, cfg_bad, tick, expire, active;
`ifdef PTS_LOOP_EN
    logic                          loop_pend, loop_d;
`endif

    // Writes land only in IDLE and only for channels that exist.
    assign cfg_ok  = cfg_we && (state == IDLE) && ({1'b0, cfg_ch} < 5'(N_CH));
    assign cfg_bad = cfg_we && !cfg_ok;

    // ---------------- config bank ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur <= '0;
            dly <= '0;
            pm  <= '0;
            dm  <= '0;
        end else if (cfg_ok) begin
            case (cfg_sel)
                2'd0:    dur[cfg_ch[CH_W-1:0]] <= cfg_data;
                2'd1:    dly[cfg_ch[CH_W-1:0]] <= cfg_data;
                2'd2:    pm[cfg_ch[CH_W-1:0]]  <= cfg_data[MULT_W-1:0];
                default: dm[cfg_ch[CH_W-1:0]]  <= cfg_data[MULT_W-1:0];
            endcase
        end
    end

    // ---------------- phase timing ----------------
    always_comb begin
        active = (state == PULSE) || (state == DELAY);
        if (state == PULSE) begin
            v = dur[ch];
            m = pm[ch];
        end else begin
            v = dly[ch];
            m = dm[ch];
        end
        tick   = (pre == m);
        // Expires on the tick that brings the tick count up to V; V=0 is a
        // single-clock phase.
        expire = active && ((v == '0) || (tick && (cnt == v - CNT_W'(1))));
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d  = state;
        ch_d     = ch;
        ch_out_d = '0;
        nxt_dur  = '0;
`ifdef PTS_LOOP_EN
        loop_d   = loop_pend;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = PULSE;
                    ch_d    = '0;
                end
            end
            PULSE: begin
                if (expire) state_d = DELAY;
            end
            DELAY: begin
                if (expire) begin
                    if (ch == CH_W'(N_CH - 1)) begin
                        state_d = DONE;
`ifdef PTS_LOOP_EN
                        loop_d  = loop;
`endif
                    end else begin
                        state_d = PULSE;
                        ch_d    = ch + CH_W'(1);
                    end
                end
            end
            default: begin // DONE
`ifdef PTS_LOOP_EN
                if (loop_pend) begin
                    state_d = PULSE;
                    ch_d    = '0;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase

        if (abort) begin
            state_d = IDLE;
`ifdef PTS_LOOP_EN
            loop_d  = 1'b0;
`endif
        end

        // A write issued together with start commits on the same edge the
        // train begins, so forward it to decide channel 0's first output.
        nxt_dur = dur[ch_d];
        if (cfg_ok && (cfg_sel == 2'd0) && (cfg_ch[CH_W-1:0] == ch_d))
            nxt_dur = cfg_data;

        if ((state_d == PULSE) && (nxt_dur != '0))
            ch_out_d[ch_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            pre     <= '0;
            cnt     <= '0;
            ch_out  <= '0;
            cfg_rej <= 1'b0;
`ifdef PTS_LOOP_EN
            loop_pend <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            ch      <= ch_d;
            ch_out  <= ch_out_d;
            cfg_rej <= cfg_bad;
`ifdef PTS_LOOP_EN
            loop_pend <= loop_d;
`endif
            // Every phase boundary is a state change, so counters restart
            // whenever the state moves or we are outside a timed phase.
            if ((state_d != state) || !active) begin
                pre <= '0;
                cnt <= '0;
            end else if (tick) begin
                pre <= '0;
                cnt <= cnt + CNT_W'(1);
            end else begin
                pre <= pre + MULT_W'(1);
            end
        end
    end

    assign busy    = (state != IDLE);
    assign end_flg = (state == DONE);
    assign cur_ch  = 4'(ch);

endmodule

// File: tb/tb_pulse_train_sequencer.sv
module tb_pulse_train_sequencer;
    localparam int N  = 16;
    localparam int N8 = 8;
    localparam int CW = 17;
    localparam int MW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_ch = '0;
    logic [1:0] cfg_sel = '0;
    logic [CW-1:0] cfg_data = '0;
    logic cfg_rej, busy, end_flg;
    logic [N-1:0] ch_out;
    logic [3:0] cur_ch;

    logic st8 = 1'b0, ab8 = 1'b0, we8 = 1'b0;
    logic [3:0] ch8 = '0;
    logic [1:0] sel8 = '0;
    logic [CW-1:0] d8 = '0;
    logic rej8, busy8, end8;
    logic [N8-1:0] out8;
    logic [3:0] cur8;
`ifdef PTS_LOOP_EN
    logic loop = 1'b0;
    logic loop8 = 1'b0;
`endif

    pulse_train_sequencer #(.N_CH(N), .CNT_W(CW), .MULT_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef PTS_LOOP_EN
        .loop(loop),
`endif
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_rej(cfg_rej), .ch_out(ch_out), .cur_ch(cur_ch), .busy(busy), .end_flg(end_flg)
    );

    pulse_train_sequencer #(.N_CH(N8), .CNT_W(CW), .MULT_W(MW)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .abort(ab8),
`ifdef PTS_LOOP_EN
        .loop(loop8),
`endif
        .cfg_we(we8), .cfg_ch(ch8), .cfg_sel(sel8), .cfg_data(d8),
        .cfg_rej(rej8), .ch_out(out8), .cur_ch(cur8), .busy(busy8), .end_flg(end8)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference config and per-cycle expectations built from phase rules.
    int m_dur[N], m_dly[N], m_pm[N], m_dm[N];
    int hi_cnt[N];

    typedef struct {
        logic [N-1:0] co;
        logic [3:0]   ch;
        logic         ef;
    } exp_t;
    exp_t expq[$];

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            m_dur[c] = 0; m_dly[c] = 0; m_pm[c] = 0; m_dm[c] = 0;
        end
    endtask

    task automatic build(input int reps);
        expq.delete();
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_t e;
                int pl, dl;
                pl = m_dur[c] * (m_pm[c] + 1);
                dl = m_dly[c] * (m_dm[c] + 1);
                if (pl < 1) pl = 1;
                if (dl < 1) dl = 1;
                e.co = '0;
                if (m_dur[c] != 0) e.co[c] = 1'b1;
                e.ch = 4'(c);
                e.ef = 1'b0;
                for (int k = 0; k < pl; k++) expq.push_back(e);
                e.co = '0;
                for (int k = 0; k < dl; k++) expq.push_back(e);
            end
            begin
                exp_t d;
                d.co = '0; d.ch = 4'(N - 1); d.ef = 1'b1;
                expq.push_back(d);
            end
        end
    endtask

    task automatic cfg_write(input int c, input int sel, input int data, input bit exp_rej);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'(c); cfg_sel = 2'(sel); cfg_data = CW'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        n_chk++;
        if (cfg_rej !== exp_rej) begin
            n_fail++;
            $display("FAIL cfg_write ch=%0d sel=%0d: cfg_rej=%b expected %b", c, sel, cfg_rej, exp_rej);
        end
        if (!exp_rej) begin
            case (sel)
                0: m_dur[c] = data;
                1: m_dly[c] = data;
                2: m_pm[c] = data % 32;
                default: m_dm[c] = data % 32;
            endcase
        end
    endtask

    // ws>=0: write ch0 duration=ws in the same cycle as start.
    // wr_at>=0: attempt a (rejected) write while busy at that train cycle index.
    // abort_at>=0: abort at that train cycle index.
    task automatic run_train(input int reps, input int abort_at, input int wr_at,
                             input int ws, output int end_cyc);
        bit stop;
        bit exp_rej;
        end_cyc = -1;
        stop = 1'b0;
        for (int c = 0; c < N; c++) hi_cnt[c] = 0;
        if (ws >= 0) m_dur[0] = ws;
        build(reps);
`ifdef PTS_LOOP_EN
        loop = (reps > 1);
`endif
        @(negedge clk);
        start = 1'b1;
        if (ws >= 0) begin
            cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 2'd0; cfg_data = CW'(ws);
        end
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b0;
        for (int i = 0; i < expq.size() && !stop; i++) begin
            exp_rej = (wr_at >= 0) && (i == wr_at + 1);
            n_chk++;
            if (ch_out !== expq[i].co || cur_ch !== expq[i].ch || end_flg !== expq[i].ef ||
                busy !== 1'b1 || cfg_rej !== exp_rej) begin
                n_fail++;
                $display("FAIL train cyc=%0d ch_out=%h exp=%h cur_ch=%0d exp=%0d end_flg=%b exp=%b busy=%b exp=1 cfg_rej=%b exp=%b",
                         i + 1, ch_out, expq[i].co, cur_ch, expq[i].ch, end_flg, expq[i].ef,
                         busy, cfg_rej, exp_rej);
            end
            for (int c = 0; c < N; c++) if (ch_out[c] === 1'b1) hi_cnt[c]++;
            if (end_flg === 1'b1 && end_cyc < 0) end_cyc = i + 1;
            if (exp_rej) cfg_we = 1'b0;
            if (i == wr_at) begin
                cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 2'd0; cfg_data = CW'(9);
            end
`ifdef PTS_LOOP_EN
            if (reps > 1 && i == (expq.size() / reps) * (reps - 1)) loop = 1'b0;
`endif
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                stop = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
`ifdef PTS_LOOP_EN
        loop = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (busy !== 1'b0 || end_flg !== 1'b0 || ch_out !== '0) begin
                n_fail++;
                $display("FAIL idle_after_train k=%0d busy=%b end_flg=%b ch_out=%h expected 0 0 0",
                         k, busy, end_flg, ch_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++;
        if (ch_out !== '0 || busy !== 1'b0 || end_flg !== 1'b0 || cur_ch !== 4'd0 || cfg_rej !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state ch_out=%h busy=%b end_flg=%b cur_ch=%0d cfg_rej=%b expected all 0",
                     ch_out, busy, end_flg, cur_ch, cfg_rej);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        int ec;
        cfg_write(0, 0, 3, 1'b0);
        cfg_write(0, 1, 2, 1'b0);
        run_train(1, -1, -10, -1, ec);
        n_chk++;
        if (ec !== 36) begin
            n_fail++;
            $display("FAIL basic_end_cycle got %0d expected 36", ec);
        end
        n_chk++;
        if (hi_cnt[0] !== 3) begin
            n_fail++;
            $display("FAIL basic_ch0_high got %0d expected 3", hi_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        int ec;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++;
        if (ch_out !== 16'h0001) begin
            n_fail++;
            $display("FAIL pre_reset_pulse ch_out=%h expected 0001", ch_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ch_out !== '0 || busy !== 1'b0 || end_flg !== 1'b0 || cur_ch !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset ch_out=%h busy=%b end_flg=%b cur_ch=%0d expected 0",
                     ch_out, busy, end_flg, cur_ch);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        run_train(1, -1, -10, -1, ec);
        n_chk++;
        if (ec !== 2 * N + 1) begin
            n_fail++;
            $display("FAIL zero_cfg_length got %0d expected %0d", ec, 2 * N + 1);
        end
    endtask

    task automatic test_multiplier();
        int ec;
        cfg_write(2, 0, 4, 1'b0);
        cfg_write(2, 2, 2, 1'b0);
        run_train(1, -1, -10, -1, ec);
        n_chk++;
        if (hi_cnt[2] !== 12) begin
            n_fail++;
            $display("FAIL mult_ch2_high got %0d expected 12", hi_cnt[2]);
        end
        cfg_write(2, 0, 0, 1'b0);
        cfg_write(2, 2, 0, 1'b0);
    endtask

    task automatic test_abort();
        int ec;
        cfg_write(0, 0, 3, 1'b0);
        cfg_write(0, 1, 2, 1'b0);
        run_train(1, 1, -10, -1, ec);
        n_chk++;
        if (ec !== -1) begin
            n_fail++;
            $display("FAIL abort_end_flg seen at cycle %0d expected none", ec);
        end
        run_train(1, -1, -10, -1, ec);
        n_chk++;
        if (ec !== 36) begin
            n_fail++;
            $display("FAIL restart_after_abort end cycle %0d expected 36", ec);
        end
    endtask

    task automatic test_reject_busy();
        int ec;
        run_train(1, -1, 3, -1, ec);
        // Model stays as it was; this train shows whether ch0 changed.
        run_train(1, -1, -10, -1, ec);
        n_chk++;
        if (hi_cnt[0] !== 3) begin
            n_fail++;
            $display("FAIL reject_busy_kept ch0 high %0d expected 3", hi_cnt[0]);
        end
    endtask

    task automatic test_random();
        int ec;
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < N; c++) begin
                cfg_write(c, 0, $urandom_range(0, 5), 1'b0);
                cfg_write(c, 1, $urandom_range(0, 5), 1'b0);
                cfg_write(c, 2, $urandom_range(0, 3), 1'b0);
                cfg_write(c, 3, $urandom_range(0, 3), 1'b0);
            end
            run_train(1, -1, -10, -1, ec);
        end
    endtask

    task automatic test_write_with_start();
        int ec;
        cfg_write(0, 2, 1, 1'b0);
        run_train(1, -1, -10, 0, ec);
        run_train(1, -1, -10, $urandom_range(1, 7), ec);
        n_chk++;
        if (hi_cnt[0] !== m_dur[0] * 2) begin
            n_fail++;
            $display("FAIL write_with_start ch0 high %0d expected %0d", hi_cnt[0], m_dur[0] * 2);
        end
    endtask

    task automatic test_reject_range();
        int cnt, endc;
        @(negedge clk);
        we8 = 1'b1; ch8 = 4'd15; sel8 = 2'd0; d8 = CW'(5);
        @(negedge clk);
        we8 = 1'b0;
        n_chk++;
        if (rej8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_range cfg_rej=%b expected 1", rej8);
        end
        @(negedge clk);
        n_chk++;
        if (rej8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_range_pulse cfg_rej=%b expected 0", rej8);
        end
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        cnt = 0; endc = -1;
        while (busy8 === 1'b1 && cnt < 100) begin
            if (end8 === 1'b1 && endc < 0) endc = cnt + 1;
            if (out8 !== '0) endc = -2;
            cnt++;
            @(negedge clk);
        end
        n_chk++;
        if (cnt !== 2 * N8 + 1 || endc !== 2 * N8 + 1) begin
            n_fail++;
            $display("FAIL reject_range_train busy cycles %0d end %0d expected %0d %0d",
                     cnt, endc, 2 * N8 + 1, 2 * N8 + 1);
        end
    endtask

`ifdef PTS_LOOP_EN
    task automatic test_loop();
        int ec;
        cfg_write(0, 0, 2, 1'b0);
        run_train(2, -1, -10, -1, ec);
        n_chk++;
        if (ec !== expq.size() / 2) begin
            n_fail++;
            $display("FAIL loop_first_end got %0d expected %0d", ec, expq.size() / 2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_multiplier();
        test_abort();
        test_reject_busy();
        test_random();
        test_write_with_start();
        test_reject_range();
`ifdef PTS_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
